// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity frame controller: FSM state
// encoding and parity mode constants.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_controller_if.sv
// Bit-serial frame bus between the receiver front end (master) and the
// parity frame controller (slave).
interface parity_frame_controller_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic                 abort;
    logic                 bit_valid;
    logic                 bit_in;
    logic                 busy;
    logic                 running_parity;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_done;
    logic                 parity_err;

    modport master (
        output start, abort, bit_valid, bit_in,
        input  busy, running_parity, data_out, frame_done, parity_err
    );

    modport slave (
        input  start, abort, bit_valid, bit_in,
        output busy, running_parity, data_out, frame_done, parity_err
    );

endinterface

// File: rtl/parity_tracker.sv
// One-bit Moore parity tracker: toggles on every accepted '1', cleared
// synchronously at the start of each frame.
module parity_tracker (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic in,
    output logic out
);

    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (clr) begin
            r_parity <= 1'b0;
        end else if (en && in) begin
            r_parity <= ~r_parity;
        end
    end

    assign out = r_parity;

endmodule

// File: rtl/parity_frame_controller.sv
// Captures DATA_BITS serial bits plus a trailing parity bit, then reports
// the assembled word together with a parity pass/fail flag.
module parity_frame_controller
    import parity_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = PAR_EVEN
) (
    input  logic clk,
    input  logic rst,
    parity_frame_controller_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_BITS) + 1;

    state_t               r_state;
    state_t               w_nextState;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_parityErr;
    logic                 w_clr;
    logic                 w_en;
    logic                 w_checkParity;
    logic                 w_lastBit;
    logic                 w_parity;

    assign w_lastBit = (r_cnt == CNT_W'(DATA_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // abort outranks bit_valid, so an aborted cycle never captures a bit
    always_comb begin
        w_nextState   = r_state;
        w_clr         = 1'b0;
        w_en          = 1'b0;
        w_checkParity = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = DATA;
                    w_clr       = 1'b1;
                end
            end
            DATA: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else if (bus.bit_valid) begin
                    w_en = 1'b1;
                    if (w_lastBit) begin
                        w_nextState = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else if (bus.bit_valid) begin
                    w_checkParity = 1'b1;
                    w_nextState   = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_data      <= '0;
            r_parityErr <= 1'b0;
        end else if (w_clr) begin
            r_cnt       <= '0;
            r_data      <= '0;
            r_parityErr <= 1'b0;
        end else if (w_en) begin
            r_data <= r_data | (DATA_BITS'(bus.bit_in) << r_cnt);
            r_cnt  <= r_cnt + CNT_W'(1);
        end else if (w_checkParity) begin
            r_parityErr <= (w_parity ^ bus.bit_in) != ODD_PARITY;
        end
    end

    parity_tracker u_tracker (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_en),
        .in  (bus.bit_in),
        .out (w_parity)
    );

    assign bus.busy           = (r_state == DATA) || (r_state == PARITY);
    assign bus.frame_done     = (r_state == DONE);
    assign bus.data_out       = r_data;
    assign bus.parity_err     = r_parityErr;
    assign bus.running_parity = w_parity;

endmodule
